// File: rtl/intra_pkg.sv
`default_nettype none
// ============================================================================
// Module     : intra_pkg
// Description: Shared sequencer state type and 1080p macroblock geometry.
// Revision   : 1.0
// ============================================================================
package intra_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } seq_state_t;

  localparam int c_MBN_W         = 13;
  localparam int c_COORD_W       = 7;
  localparam int c_MB_COLS_1080P = 120;
  localparam int c_MB_ROWS_1080P = 68;

endpackage
`default_nettype wire

// File: rtl/mb_avail.sv
`default_nettype none
// ============================================================================
// Module     : mb_avail
// Description: Neighbour-availability flags for a macroblock position.
// Revision   : 1.0
// ============================================================================
module mb_avail
  import intra_pkg::*;
#(
  parameter int MB_COLS = c_MB_COLS_1080P,
  parameter int COORD_W = c_COORD_W
) (
  input  logic [COORD_W-1:0] mb_x,
  input  logic [COORD_W-1:0] mb_y,
  output logic               avail_left,
  output logic               avail_top,
  output logic               avail_topleft,
  output logic               avail_topright
);

  localparam logic [COORD_W-1:0] c_LAST_X = COORD_W'(MB_COLS - 1);

  logic w_has_left;
  logic w_has_top;

  assign w_has_left     = (mb_x != '0);
  assign w_has_top      = (mb_y != '0);
  assign avail_left     = w_has_left;
  assign avail_top      = w_has_top;
  assign avail_topleft  = w_has_left & w_has_top;
  assign avail_topright = w_has_top & (mb_x < c_LAST_X);

endmodule
`default_nettype wire

// File: rtl/intra_mb_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : intra_mb_sequencer
// Description: Raster-order macroblock issuer with start/done handshake.
// Revision   : 1.0
// ============================================================================
module intra_mb_sequencer
  import intra_pkg::*;
#(
  parameter int MB_COLS = c_MB_COLS_1080P,
  parameter int MB_ROWS = c_MB_ROWS_1080P,
  parameter int MBN_W   = c_MBN_W,
  parameter int COORD_W = c_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               mb_done,
  output logic               mb_start,
  output logic [MBN_W-1:0]   mbnumber,
  output logic [COORD_W-1:0] mb_x,
  output logic [COORD_W-1:0] mb_y,
  output logic               avail_left,
  output logic               avail_top,
  output logic               avail_topleft,
  output logic               avail_topright,
  output logic               busy,
  output logic               frame_done
);

  if (MB_COLS * MB_ROWS > 2**MBN_W) begin : g_mbn_w_check
    $error("MBN_W too narrow for MB_COLS*MB_ROWS");
  end
  if ((MB_COLS - 1 >= 2**COORD_W) || (MB_ROWS - 1 >= 2**COORD_W)) begin : g_coord_w_check
    $error("COORD_W too narrow for frame dimensions");
  end

  localparam logic [MBN_W-1:0]   c_LAST_MB = MBN_W'(MB_COLS * MB_ROWS - 1);
  localparam logic [COORD_W-1:0] c_LAST_X  = COORD_W'(MB_COLS - 1);

  seq_state_t         r_state, w_state_nxt;
  logic [MBN_W-1:0]   r_mbnumber, w_mbn_nxt;
  logic [COORD_W-1:0] r_mb_x, w_x_nxt;
  logic [COORD_W-1:0] r_mb_y, w_y_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done_pending, w_pending_nxt;
  logic               w_mb_start, w_frame_done;
  logic               r_av_left, r_av_top, r_av_topleft, r_av_topright;
  logic               w_av_left, w_av_top, w_av_topleft, w_av_topright;

  always_comb begin
    w_state_nxt   = r_state;
    w_mbn_nxt     = r_mbnumber;
    w_x_nxt       = r_mb_x;
    w_y_nxt       = r_mb_y;
    w_busy_nxt    = r_busy;
    w_pending_nxt = r_done_pending;
    w_mb_start    = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && frame_start) begin
          w_state_nxt   = ISSUE;
          w_mbn_nxt     = '0;
          w_x_nxt       = '0;
          w_y_nxt       = '0;
          w_busy_nxt    = 1'b1;
          w_pending_nxt = 1'b0;
        end
      end
      ISSUE: begin
        if (enable) begin
          w_mb_start  = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (enable && (mb_done || r_done_pending)) begin
          w_pending_nxt = 1'b0;
          if (r_mbnumber == c_LAST_MB) begin
            w_state_nxt = FLUSH;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = ISSUE;
            w_mbn_nxt   = r_mbnumber + 1'b1;
            if (r_mb_x == c_LAST_X) begin
              w_x_nxt = '0;
              w_y_nxt = r_mb_y + 1'b1;
            end else begin
              w_x_nxt = r_mb_x + 1'b1;
            end
          end
        end else if (mb_done) begin
          // Done seen while frozen is held until enable returns.
          w_pending_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (enable) begin
          w_frame_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  mb_avail #(
    .MB_COLS (MB_COLS),
    .COORD_W (COORD_W)
  ) u_mb_avail (
    .mb_x           (w_x_nxt),
    .mb_y           (w_y_nxt),
    .avail_left     (w_av_left),
    .avail_top      (w_av_top),
    .avail_topleft  (w_av_topleft),
    .avail_topright (w_av_topright)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mbnumber     <= '0;
      r_mb_x         <= '0;
      r_mb_y         <= '0;
      r_busy         <= 1'b0;
      r_done_pending <= 1'b0;
      r_av_left      <= 1'b0;
      r_av_top       <= 1'b0;
      r_av_topleft   <= 1'b0;
      r_av_topright  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mbnumber     <= w_mbn_nxt;
      r_mb_x         <= w_x_nxt;
      r_mb_y         <= w_y_nxt;
      r_busy         <= w_busy_nxt;
      r_done_pending <= w_pending_nxt;
      r_av_left      <= w_av_left;
      r_av_top       <= w_av_top;
      r_av_topleft   <= w_av_topleft;
      r_av_topright  <= w_av_topright;
    end
  end

  assign mb_start       = w_mb_start;
  assign frame_done     = w_frame_done;
  assign mbnumber       = r_mbnumber;
  assign mb_x           = r_mb_x;
  assign mb_y           = r_mb_y;
  assign busy           = r_busy;
  assign avail_left     = r_av_left;
  assign avail_top      = r_av_top;
  assign avail_topleft  = r_av_topleft;
  assign avail_topright = r_av_topright;

  a_done_in_wait: assert property (@(posedge clk) disable iff (reset)
    !(mb_done && (r_state != WAIT)))
    else $warning("mb_done outside WAIT ignored");

endmodule
`default_nettype wire

// File: tb/tb_intra_mb_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_intra_mb_sequencer
// Description: Scoreboard bench for the macroblock sequencer (4x3 and 1080p).
// Revision   : 1.0
// ============================================================================
module tb_intra_mb_sequencer;
  import intra_pkg::*;

  localparam int c_COLS = 4;
  localparam int c_ROWS = 3;
  localparam int c_NMB  = c_COLS * c_ROWS;
  localparam int c_BIG  = c_MB_COLS_1080P * c_MB_ROWS_1080P;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic enable = 1'b1, frame_start = 1'b0, mb_done = 1'b0;
  logic mb_start, busy, frame_done;
  logic avail_left, avail_top, avail_topleft, avail_topright;
  logic [12:0] mbnumber;
  logic [6:0]  mb_x, mb_y;

  logic b_enable = 1'b1, b_frame_start = 1'b0, b_mb_done = 1'b0;
  logic b_mb_start, b_busy, b_frame_done;
  logic b_al, b_at, b_atl, b_atr;
  logic [12:0] b_mbnumber;
  logic [6:0]  b_mb_x, b_mb_y;

  intra_mb_sequencer #(.MB_COLS(c_COLS), .MB_ROWS(c_ROWS), .MBN_W(13), .COORD_W(7)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .mb_done(mb_done), .mb_start(mb_start), .mbnumber(mbnumber), .mb_x(mb_x),
    .mb_y(mb_y), .avail_left(avail_left), .avail_top(avail_top),
    .avail_topleft(avail_topleft), .avail_topright(avail_topright),
    .busy(busy), .frame_done(frame_done)
  );

  intra_mb_sequencer dut_big (
    .clk(clk), .reset(reset), .enable(b_enable), .frame_start(b_frame_start),
    .mb_done(b_mb_done), .mb_start(b_mb_start), .mbnumber(b_mbnumber), .mb_x(b_mb_x),
    .mb_y(b_mb_y), .avail_left(b_al), .avail_top(b_at),
    .avail_topleft(b_atl), .avail_topright(b_atr),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  typedef struct {
    logic [31:0] mbn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] av;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_fd     = 0;
  int b_cnt    = 0;
  int b_fd     = 0;
  logic [31:0] b_last_mbn, b_last_x, b_last_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Expected MB list from raster geometry (div/mod), independent of the DUT's counters.
  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < c_NMB; i++) begin
      int x, y;
      x = i % c_COLS;
      y = i / c_COLS;
      e.mbn = 32'(i);
      e.x   = 32'(x);
      e.y   = 32'(y);
      e.av  = {28'd0, (x > 0), (y > 0), (x > 0 && y > 0), (y > 0 && x < c_COLS - 1)};
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mb_start) begin
      n_start++;
      if (exp_q.size() == 0) begin
        check("mb_start_expected", 32'(mb_start), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mbnumber", 32'(mbnumber), e.mbn);
        check("mb_x", 32'(mb_x), e.x);
        check("mb_y", 32'(mb_y), e.y);
        check("avail", 32'({avail_left, avail_top, avail_topleft, avail_topright}), e.av);
      end
    end
    if (frame_done) begin
      n_fd++;
      check("busy_at_frame_done", 32'(busy), 32'd0);
    end
    if (b_mb_start) begin
      check("big_mbnumber", 32'(b_mbnumber), 32'(b_cnt));
      b_cnt++;
      b_last_mbn = 32'(b_mbnumber);
      b_last_x   = 32'(b_mb_x);
      b_last_y   = 32'(b_mb_y);
    end
    if (b_frame_done) b_fd++;
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mb_start) begin
        ok = 1'b1;
        return;
      end
    end
    check("mb_start_timeout", 32'(mb_start), 32'd1);
  endtask

  task automatic run_frame(input int lat, input int spur_mb, input int freeze_mb, input int reset_mb);
    bit ok;
    @(posedge clk); #1 frame_start = 1'b1;
    push_frame();
    @(posedge clk); #1 frame_start = 1'b0;
    for (int m = 0; m < c_NMB; m++) begin
      wait_start(ok);
      if (!ok) return;
      if (m == reset_mb) begin
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("rst_coords", 32'({mbnumber, mb_x, mb_y}), 32'd0);
        check("rst_ctrl", 32'({mb_start, avail_left, avail_top, avail_topleft, avail_topright, busy, frame_done}), 32'd0);
        exp_q.delete();
        return;
      end
      if (m == freeze_mb) begin
        @(posedge clk); #1 enable = 1'b0; mb_done = 1'b1;
        @(posedge clk); #1 mb_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("freeze_mbnumber", 32'(mbnumber), 32'(m));
        check("freeze_busy", 32'(busy), 32'd1);
        enable = 1'b1;
      end else begin
        for (int c = 0; c < lat; c++) begin
          @(posedge clk); #1;
          frame_start = (m == spur_mb && c == 0);
        end
        frame_start = 1'b0;
        mb_done = 1'b1;
        @(posedge clk); #1 mb_done = 1'b0;
      end
    end
  endtask

  initial begin
    int s0, f0;
    bit done_seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_no_start", 32'(n_start), 32'd0);
    check("idle_coords", 32'({mbnumber, mb_x, mb_y}), 32'd0);
    check("idle_ctrl", 32'({mb_start, avail_left, avail_top, avail_topleft, avail_topright, busy, frame_done}), 32'd0);

    @(posedge clk); #1 mb_done = 1'b1;
    @(posedge clk); #1 mb_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_mbnumber", 32'(mbnumber), 32'd0);
    check("idle_done_busy", 32'(busy), 32'd0);

    // Frame A: 3-cycle latency, freeze on MB2, spurious frame_start on MB5.
    s0 = n_start; f0 = n_fd;
    run_frame(3, 5, 2, -1);
    repeat (5) @(negedge clk);
    check("frameA_starts", 32'(n_start - s0), 32'(c_NMB));
    check("frameA_frame_done", 32'(n_fd - f0), 32'd1);
    check("frameA_queue_empty", 32'(exp_q.size()), 32'd0);
    check("frameA_busy_after", 32'(busy), 32'd0);

    // Frame B: reset asynchronously during WAIT of MB6.
    f0 = n_fd;
    run_frame(2, -1, -1, 6);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("frameB_no_frame_done", 32'(n_fd - f0), 32'd0);
    check("frameB_idle_busy", 32'(busy), 32'd0);

    // Frame C: restart after reset, minimum period.
    s0 = n_start; f0 = n_fd;
    run_frame(1, -1, -1, -1);
    repeat (5) @(negedge clk);
    check("frameC_starts", 32'(n_start - s0), 32'(c_NMB));
    check("frameC_frame_done", 32'(n_fd - f0), 32'd1);
    check("frameC_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full 1080p frame with 1-cycle done latency.
    @(posedge clk); #1 b_frame_start = 1'b1;
    @(posedge clk); #1 b_frame_start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 3 * c_BIG + 20 && !done_seen; i++) begin
      @(negedge clk);
      if (b_mb_start) begin
        @(posedge clk); #1 b_mb_done = 1'b1;
        @(posedge clk); #1 b_mb_done = 1'b0;
      end
      if (b_fd != 0) done_seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("big_starts", 32'(b_cnt), 32'(c_BIG));
    check("big_frame_done", 32'(b_fd), 32'd1);
    check("big_last_mbn", b_last_mbn, 32'(c_BIG - 1));
    check("big_last_x", b_last_x, 32'(c_MB_COLS_1080P - 1));
    check("big_last_y", b_last_y, 32'(c_MB_ROWS_1080P - 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/intra_mb_sequencer.md
Name: intra_mb_sequencer

Overview:
- Upstream frame-level controller for the intraloop stage.
- Walks a frame in raster order and issues one macroblock at a time to intraloop: mbnumber, MB coordinates, neighbour-availability flags, and a start pulse.
- Waits for intraloop's done before advancing; pulses frame_done after the last MB.
- Replaces free-running mbnumber generation with a start/done handshake.

Parameters:
- MB_COLS, 120, frame width in macroblocks (1920 px).
- MB_ROWS, 68, frame height in macroblocks (1088 px).
- MBN_W, 13, mbnumber width. MB_COLS*MB_ROWS <= 2**MBN_W is required; elaboration fails otherwise.
- COORD_W, 7, mb_x/mb_y width. Must hold MB_COLS-1 and MB_ROWS-1.

Ports:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  asynchronous, active-high.
- enable  in  1  global advance enable; low freezes the FSM.
- frame_start  in  1  single-cycle request to begin a frame.
- mb_done  in  1  single-cycle pulse from intraloop: current MB finished.
- mb_start  out  1  single-cycle pulse: mbnumber/mb_x/mb_y/avail_* are valid, begin this MB.
- mbnumber  out  MBN_W  raster index of the current MB.
- mb_x  out  COORD_W  MB column.
- mb_y  out  COORD_W  MB row.
- avail_left  out  1  left neighbour exists (mb_x>0).
- avail_top  out  1  top neighbour exists (mb_y>0).
- avail_topleft  out  1  mb_x>0 and mb_y>0.
- avail_topright  out  1  mb_y>0 and mb_x<MB_COLS-1.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  single-cycle pulse after the last MB's mb_done.

Behaviour:
- Reset (async assert, sync-safe release) clears all state and outputs:
  - state=IDLE; mbnumber, mb_x, mb_y = 0; mb_start, frame_done, busy = 0; all avail_* = 0; done_pending=0.
  - Reset mid-frame abandons the frame; no frame_done is issued.
- FSM states: IDLE, ISSUE, WAIT, FLUSH. All transitions occur only when enable=1, except done capture (below).
- IDLE:
  - On frame_start=1: clear counters, set busy=1, go to ISSUE.
  - frame_start while busy is ignored; it is not queued.
- ISSUE:
  - mb_start=1 for exactly one cycle, with coords/flags registered and stable that cycle; go to WAIT.
  - Coords and flags hold until the next advance.
- WAIT:
  - On mb_done, or done_pending=1: clear done_pending.
  - If mbnumber==MB_COLS*MB_ROWS-1, go to FLUSH.
  - Otherwise advance and go to ISSUE.
  - Minimum MB period is therefore 2 cycles (ISSUE, then WAIT seeing done).
- Advance:
  - mbnumber+1.
  - If mb_x==MB_COLS-1: mb_x=0 and mb_y+1; else mb_x+1.
  - mbnumber is maintained by increment, not a multiplier.
  - avail_* are registered from the next coordinates, so they are valid in the ISSUE cycle.
- FLUSH: frame_done=1 for one cycle, busy=0, go to IDLE. Outputs keep the last MB's values.
- enable=0:
  - State, counters and outputs hold; mb_start and frame_done are forced 0.
  - A pending ISSUE or FLUSH pulse is emitted on the first cycle enable returns.
  - An mb_done arriving while enable=0 in WAIT sets done_pending, so it is never lost.
- mb_done outside WAIT (IDLE, ISSUE, FLUSH) is ignored; an assertion flags it in simulation.
- frame_start and mb_done in the same cycle in IDLE: frame_start wins and mb_done is ignored.
- No wrap beyond the last MB: counters never exceed MB_COLS-1, MB_ROWS-1, or MB_COLS*MB_ROWS-1.

Decomposition:
- Shared package intra_pkg holds:
  - the seq_state_t enum (IDLE, ISSUE, WAIT, FLUSH);
  - MBN_W and COORD_W defaults;
  - 1080p MB_COLS/MB_ROWS constants, shared with intraloop and its neighbour buffers.
- One natural sub-module, mb_avail: takes next mb_x/mb_y and MB_COLS and produces the four avail flags. It is reused by the neighbour-pixel line buffer.

Test Plan (MB_COLS=4, MB_ROWS=3 unless stated):
- Reset then idle 10 cycles -> all outputs 0, no mb_start.
- frame_start, mb_done returned 3 cycles after each mb_start:
  - 12 mb_start pulses with mbnumber 0..11.
  - (mb_x,mb_y) runs (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2).
  - One frame_done after the 12th mb_done; busy falls in the same cycle.
- Availability checks:
  - MB0 -> all avail 0.
  - MB3 -> left=1, top=0, topright=0.
  - MB5 -> left, top, topleft, topright all 1.
  - MB7 -> topright=0.
  - MB8 -> left=0, top=1, topright=1.
- mb_done pulsed while enable=0 during WAIT of MB2, enable restored 5 cycles later -> MB3 mb_start on the first enabled ISSUE cycle; no MB skipped or repeated.
- Spurious inputs -> second frame_start mid-frame ignored (still 12 MBs, one frame_done); mb_done during IDLE ignored (mbnumber stays 0).
- Reset asserted asynchronously (mid-cycle) during WAIT of MB6 -> outputs 0 immediately, no frame_done. A new frame_start restarts at mbnumber 0.
- Defaults MB_COLS=120, MB_ROWS=68 with 1-cycle done latency -> last mb_start has mbnumber 8159, mb_x=119, mb_y=67; exactly 8160 mb_start pulses.
